// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the multi-channel clock divider.
package clkdiv_pkg;

    // Widest divisor/counter width any instance may be built with.
    localparam int CW_MAX = 16;

    // Divisor storage type. Instances narrow it to their own CW bits.
    typedef logic [CW_MAX-1:0] div_t;

    // A divisor of zero has no meaning and is rejected at the config port.
    localparam div_t DIV_ILLEGAL = '0;

    // Width of a channel-select field. It is never zero, even for one channel.
    function automatic int ch_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_multi_if.sv
// Config port of the divider.
// Handshake: a transfer happens on a rising clk edge where cfg_valid and
// cfg_ready are both high. The requester holds cfg_ch/cfg_div stable while
// cfg_valid is high and not yet accepted. cfg_ready may depend combinationally
// on cfg_ch. cfg_err is a registered one-cycle pulse that follows an accepted
// illegal request.
interface clkdiv_multi_if
    import clkdiv_pkg::*;
#(
    parameter int NCH = 2,
    parameter int CW  = 8
);
    localparam int CHW = ch_width(NCH);

    logic           cfg_valid;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic           cfg_ready;
    logic           cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/clkdiv_chan.sv
// One divider channel: phase counter, active and shadow divisor, pending flag,
// and the registered divided clock and period-start tick.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int   CW          = 8,
    parameter div_t DEFAULT_DIV = div_t'(3)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          ld_i,      // accepted legal config for this channel
    input  logic [CW-1:0] ld_div_i,
    output logic          clk_out_o,
    output logic          tick_o,
    output logic          pending_o
);
    localparam logic [CW-1:0] DEF_DIV = DEFAULT_DIV[CW-1:0];

    logic [CW-1:0] p_q, p_d;
    logic [CW-1:0] act_q, act_d;
    logic [CW-1:0] sh_q, sh_d;
    logic          pending_q, pending_d;
    logic          clk_out_q, clk_out_d;
    logic          tick_q, tick_d;

    logic          last;
    logic          apply;
    logic [CW-1:0] p_nxt;

    // Next-state: advance phase, swap in the shadow divisor at a period
    // boundary (or immediately while stopped), and form the output flops.
    always_comb begin
        last      = (p_q == act_q - CW'(1));
        p_nxt     = last ? '0 : p_q + CW'(1);
        // The shadow is applied when the period ends or the channel is idle.
        // The new divisor then shapes the period that starts on this edge.
        apply     = pending_q && (last || !en_i);
        act_d     = apply ? sh_q : act_q;
        pending_d = apply ? 1'b0 : pending_q;
        sh_d      = sh_q;
        p_d       = p_q;
        clk_out_d = 1'b0;
        tick_d    = 1'b0;

        if (en_i) begin
            p_d       = p_nxt;
            clk_out_d = (p_nxt < (act_d >> 1));
            tick_d    = (p_nxt == '0);
        end else begin
            // Re-arm so the first enabled edge wraps and starts a fresh period.
            p_d = act_d - CW'(1);
        end

        // A load only arrives while nothing is pending, so it never
        // collides with an apply on the same edge.
        if (ld_i) begin
            sh_d      = ld_div_i;
            pending_d = 1'b1;
        end
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q       <= DEF_DIV - CW'(1);
            act_q     <= DEF_DIV;
            sh_q      <= '0;
            pending_q <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            p_q       <= p_d;
            act_q     <= act_d;
            sh_q      <= sh_d;
            pending_q <= pending_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel runtime-programmable clock divider. Decodes the config port,
// drives cfg_ready/cfg_err and instantiates one clkdiv_chan per channel.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int   NCH         = 2,
    parameter int   CW          = 8,
    parameter div_t DEFAULT_DIV = div_t'(3)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH-1:0]     en,
    clkdiv_multi_if.slave      cfg,
    output logic [NCH-1:0]     clk_out,
    output logic [NCH-1:0]     tick,
    output logic [NCH-1:0]     pending
);
    localparam int CHW = ch_width(NCH);

    logic [NCH-1:0] ld;
    logic           ch_legal;
    logic           div_legal;
    logic           ready;
    logic           cfg_err_q, cfg_err_d;

    // Channel decode and ready mux. An out-of-range channel matches no
    // channel, so it sees ready=1 and is flagged illegal.
    always_comb begin
        ch_legal = 1'b0;
        ready    = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            if (cfg.cfg_ch == CHW'(c)) begin
                ch_legal = 1'b1;
                ready    = !pending[c];
            end
        end
        div_legal = (cfg.cfg_div != DIV_ILLEGAL[CW-1:0]);
        cfg_err_d = cfg.cfg_valid && ready && !(ch_legal && div_legal);
    end

    // Error pulse register: high for exactly the cycle after an illegal transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg.cfg_ready = ready;
    assign cfg.cfg_err   = cfg_err_q;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        assign ld[c] = cfg.cfg_valid && div_legal && !pending[c] &&
                       (cfg.cfg_ch == CHW'(c));

        clkdiv_chan #(
            .CW          (CW),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .en_i      (en[c]),
            .ld_i      (ld[c]),
            .ld_div_i  (cfg.cfg_div),
            .clk_out_o (clk_out[c]),
            .tick_o    (tick[c]),
            .pending_o (pending[c])
        );
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed bench for clkdiv_multi: a 2-channel instance for the main walk and
// a 3-channel instance for an out-of-range channel select.
module tb_clkdiv_multi;
    import clkdiv_pkg::*;

    logic       clk;
    logic       rst;
    logic [1:0] en;
    logic [1:0] clk_out;
    logic [1:0] tick;
    logic [1:0] pending;
    logic [2:0] en3;
    logic [2:0] clk_out3;
    logic [2:0] tick3;
    logic [2:0] pending3;

    int total = 0;
    int bad   = 0;

    clkdiv_multi_if #(.NCH(2), .CW(8)) cfg  ();
    clkdiv_multi_if #(.NCH(3), .CW(8)) cfg3 ();

    clkdiv_multi #(.NCH(2), .CW(8), .DEFAULT_DIV(div_t'(3))) u_dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .cfg     (cfg.slave),
        .clk_out (clk_out),
        .tick    (tick),
        .pending (pending)
    );

    clkdiv_multi #(.NCH(3), .CW(8), .DEFAULT_DIV(div_t'(3))) u_dut3 (
        .clk     (clk),
        .rst     (rst),
        .en      (en3),
        .cfg     (cfg3.slave),
        .clk_out (clk_out3),
        .tick    (tick3),
        .pending (pending3)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and check {ch1,ch0} clk_out, tick and pending.
    task automatic step(input string tag, input logic [1:0] co, input logic [1:0] tk,
                        input logic [1:0] pd);
        @(posedge clk);
        #1;
        chk({tag, "_clk_out"}, 16'(clk_out), 16'(co));
        chk({tag, "_tick"},    16'(tick),    16'(tk));
        chk({tag, "_pending"}, 16'(pending), 16'(pd));
    endtask

    initial begin
        rst            = 1'b1;
        en             = 2'b11;
        en3            = 3'b111;
        cfg.cfg_valid  = 1'b0;
        cfg.cfg_ch     = '0;
        cfg.cfg_div    = '0;
        cfg3.cfg_valid = 1'b0;
        cfg3.cfg_ch    = '0;
        cfg3.cfg_div   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_clk_out", 16'(clk_out), 16'h0);
        chk("rst_tick",    16'(tick),    16'h0);
        chk("rst_pending", 16'(pending), 16'h0);
        chk("rst_ready",   16'(cfg.cfg_ready), 16'h1);
        chk("rst_err",     16'(cfg.cfg_err),   16'h0);
        rst = 1'b0;

        // Default divide by 3 on both channels
        step("e1", 2'b11, 2'b11, 2'b00);
        step("e2", 2'b00, 2'b00, 2'b00);
        step("e3", 2'b00, 2'b00, 2'b00);
        step("e4", 2'b11, 2'b11, 2'b00);
        step("e5", 2'b00, 2'b00, 2'b00);
        step("e6", 2'b00, 2'b00, 2'b00);
        step("e7", 2'b11, 2'b11, 2'b00);
        step("e8", 2'b00, 2'b00, 2'b00);

        // ch1 -> D=4 requested at p=1; current period completes first
        cfg.cfg_valid = 1'b1;
        cfg.cfg_ch    = 1'b1;
        cfg.cfg_div   = 8'd4;
        step("e9", 2'b00, 2'b00, 2'b10);
        chk("e9_ready_ch1_busy", 16'(cfg.cfg_ready), 16'h0);
        cfg.cfg_valid = 1'b0;
        cfg.cfg_ch    = 1'b0;
        #1;
        chk("e9_ready_ch0_free", 16'(cfg.cfg_ready), 16'h1);
        step("e10", 2'b11, 2'b11, 2'b00);
        step("e11", 2'b10, 2'b00, 2'b00);
        step("e12", 2'b00, 2'b00, 2'b00);
        step("e13", 2'b01, 2'b01, 2'b00);
        step("e14", 2'b10, 2'b10, 2'b00);

        // ch0 -> D=1 takes effect at its next wrap
        cfg.cfg_valid = 1'b1;
        cfg.cfg_ch    = 1'b0;
        cfg.cfg_div   = 8'd1;
        step("e15", 2'b10, 2'b00, 2'b01);
        cfg.cfg_valid = 1'b0;
        step("e16", 2'b00, 2'b01, 2'b00);
        step("e17", 2'b00, 2'b01, 2'b00);
        step("e18", 2'b10, 2'b11, 2'b00);
        step("e19", 2'b10, 2'b01, 2'b00);

        // ch0 -> D=4, then drop en[0] at p=1 for three cycles
        cfg.cfg_valid = 1'b1;
        cfg.cfg_ch    = 1'b0;
        cfg.cfg_div   = 8'd4;
        step("e20", 2'b00, 2'b01, 2'b01);
        cfg.cfg_valid = 1'b0;
        step("e21", 2'b01, 2'b01, 2'b00);
        step("e22", 2'b11, 2'b10, 2'b00);
        en = 2'b10;
        step("e23", 2'b10, 2'b00, 2'b00);
        step("e24", 2'b00, 2'b00, 2'b00);
        step("e25", 2'b00, 2'b00, 2'b00);
        en = 2'b11;
        step("e26", 2'b11, 2'b11, 2'b00);
        step("e27", 2'b11, 2'b00, 2'b00);
        step("e28", 2'b00, 2'b00, 2'b00);
        step("e29", 2'b00, 2'b00, 2'b00);
        step("e30", 2'b11, 2'b11, 2'b00);

        // Illegal requests: divisor 0 on the 2-channel part, channel 3 on the 3-channel part
        cfg.cfg_valid  = 1'b1;
        cfg.cfg_ch     = 1'b0;
        cfg.cfg_div    = 8'd0;
        cfg3.cfg_valid = 1'b1;
        cfg3.cfg_ch    = 2'd3;
        cfg3.cfg_div   = 8'd5;
        #1;
        chk("ill_div_ready", 16'(cfg.cfg_ready),  16'h1);
        chk("ill_ch_ready",  16'(cfg3.cfg_ready), 16'h1);
        step("e31", 2'b11, 2'b00, 2'b00);
        chk("e31_err",      16'(cfg.cfg_err),  16'h1);
        chk("e31_err3",     16'(cfg3.cfg_err), 16'h1);
        chk("e31_pending3", 16'(pending3),     16'h0);
        cfg.cfg_valid  = 1'b0;
        cfg3.cfg_valid = 1'b0;
        step("e32", 2'b00, 2'b00, 2'b00);
        chk("e32_err",  16'(cfg.cfg_err),  16'h0);
        chk("e32_err3", 16'(cfg3.cfg_err), 16'h0);
        step("e33", 2'b00, 2'b00, 2'b00);
        step("e34", 2'b11, 2'b11, 2'b00);

        // ch1 pending D=5 mid-period, then a one-cycle reset
        cfg.cfg_valid = 1'b1;
        cfg.cfg_ch    = 1'b1;
        cfg.cfg_div   = 8'd5;
        step("e35", 2'b11, 2'b00, 2'b10);
        cfg.cfg_valid = 1'b0;
        rst = 1'b1;
        step("e36", 2'b00, 2'b00, 2'b00);
        chk("e36_err", 16'(cfg.cfg_err), 16'h0);
        rst = 1'b0;
        step("e37", 2'b11, 2'b11, 2'b00);
        step("e38", 2'b00, 2'b00, 2'b00);
        step("e39", 2'b00, 2'b00, 2'b00);
        step("e40", 2'b11, 2'b11, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
